guess_capture: RTL and testbench

GUESS_CAPTURE -- requirements
Module: guess_capture

---
 rtl/hangman_pkg.sv | 28 ++
 rtl/key_debounce.sv | 52 +++++
 rtl/guess_capture.sv | 154 +++++++++++++++
 tb/tb_guess_capture.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: letter-code constants, the guess-capture FSM state type and
// small helpers shared by the guess capture logic.
package hangman_pkg;

  localparam int          CODE_W      = 6;
  localparam int unsigned LETTER_A    = 32'h0A;
  localparam int unsigned LETTER_Z    = 32'h23;
  localparam int unsigned DASH        = 32'h00;
  localparam int unsigned NUM_LETTERS = LETTER_Z - LETTER_A + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    ISSUE,
    RELEASE_DB
  } capture_state_e;

  // Only A..Z are letters; the dash and every code outside A..Z are not.
  function automatic logic is_letter(input int unsigned code);
    return (code != DASH) && (code >= LETTER_A) && (code <= LETTER_Z);
  endfunction

  // Position of a letter inside the guess history (A = 0).
  function automatic logic [4:0] letter_index(input int unsigned code);
    return 5'(code - LETTER_A);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer for the go key plus a stable-sample
// counter. key_db_o only changes after DEBOUNCE_CYCLES consecutive samples of
// the new level; the counter never wraps because it restarts on every flip.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  input  logic clr_i,
  output logic key_sync_o,
  output logic key_db_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta_q;
  logic             key_sync_q;
  logic             key_db_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize the raw key; idles released (high).
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_n_i;
      key_sync_q <= key_meta_q;
    end
  end

  // Count consecutive samples that differ from the debounced level.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q    <= '0;
      key_db_q <= 1'b1;
    end else if (clr_i || (key_sync_q == key_db_q)) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      key_db_q <= key_sync_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign key_sync_o = key_sync_q;
  assign key_db_o   = key_db_q;

endmodule

// File: rtl/guess_capture.sv
// guess_capture: debounces the go key, captures the switch letter code and
// hands it to the game controller over a valid/ready handshake.
// Optional build macro GUESS_DUP_FILTER_EN keeps a history of accepted
// letters and rejects repeats with a dup_guess pulse instead of issuing them.
//
//   state      | meaning
//   IDLE       | waiting for the synchronized key to go low
//   PRESS_DB   | key low, waiting for the debounced press
//   ISSUE      | guess_valid high, guess_code frozen until ready or new_game
//   RELEASE_DB | waiting for a debounced release before the next press
module guess_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CODE_W          = hangman_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] sw_guess,
  input  logic              key_go_n,
  input  logic              new_game,
  output logic              guess_valid,
  input  logic              guess_ready,
  output logic [CODE_W-1:0] guess_code,
  output logic              bad_letter,
  output logic              dup_guess,
  output logic [4:0]        guess_count
);

  import hangman_pkg::*;

  logic [CODE_W-1:0] sw_meta_q;
  logic [CODE_W-1:0] sw_sync_q;
  logic              key_sync;
  logic              key_db;
  logic              db_clr;
  logic              code_legal;
  capture_state_e    state_q;
  logic              valid_q;
  logic              bad_q;
  logic [CODE_W-1:0] code_q;
  logic [4:0]        count_q;
`ifdef GUESS_DUP_FILTER_EN
  logic                   dup_q;
  logic [NUM_LETTERS-1:0] hist_q;
`endif

  // Synchronize the switch code before it is ever looked at.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_guess;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign db_clr     = (state_q == IDLE);
  assign code_legal = is_letter(32'(sw_sync_q));

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .resetn     (resetn),
    .key_n_i    (key_go_n),
    .clr_i      (db_clr),
    .key_sync_o (key_sync),
    .key_db_o   (key_db)
  );

  // Capture FSM with registered handshake, status pulses, count and history.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      code_q  <= '0;
      count_q <= '0;
`ifdef GUESS_DUP_FILTER_EN
      dup_q   <= 1'b0;
      hist_q  <= '0;
`endif
    end else begin
      bad_q <= 1'b0;
`ifdef GUESS_DUP_FILTER_EN
      dup_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!key_sync) state_q <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!key_db) begin
            code_q <= sw_sync_q;
            if (!code_legal) begin
              bad_q   <= 1'b1;
              state_q <= RELEASE_DB;
            end
`ifdef GUESS_DUP_FILTER_EN
            else if (hist_q[letter_index(32'(sw_sync_q))]) begin
              dup_q   <= 1'b1;
              state_q <= RELEASE_DB;
            end
`endif
            else begin
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          end else if (key_sync) begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (new_game) begin
            valid_q <= 1'b0;
            state_q <= RELEASE_DB;
          end else if (guess_ready) begin
            valid_q <= 1'b0;
            count_q <= (count_q == 5'd31) ? count_q : count_q + 5'd1;
`ifdef GUESS_DUP_FILTER_EN
            hist_q[letter_index(32'(code_q))] <= 1'b1;
`endif
            state_q <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (key_db) state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // A new game overrides any transfer landing on the same edge.
      if (new_game) begin
        count_q <= '0;
`ifdef GUESS_DUP_FILTER_EN
        hist_q  <= '0;
`endif
      end
    end
  end

  assign guess_valid = valid_q;
  assign guess_code  = code_q;
  assign bad_letter  = bad_q;
  assign guess_count = count_q;
`ifdef GUESS_DUP_FILTER_EN
  assign dup_guess   = dup_q;
`else
  assign dup_guess   = 1'b0;
`endif

endmodule

// File: tb/tb_guess_capture.sv
// tb_guess_capture: directed presses against a behavioural model of the
// guess capture block (expected outcomes, letter history, accepted count).
module tb_guess_capture;

  localparam int DB      = 4;
  localparam int K_ISSUE = 0;
  localparam int K_BAD   = 1;
  localparam int K_DUP   = 2;
`ifdef GUESS_DUP_FILTER_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] sw_guess = '0;
  logic       key_go_n = 1'b1;
  logic       new_game = 1'b0;
  logic       guess_ready = 1'b0;
  logic       guess_valid;
  logic [5:0] guess_code;
  logic       bad_letter;
  logic       dup_guess;
  logic [4:0] guess_count;

  guess_capture #(.DEBOUNCE_CYCLES(DB), .CODE_W(6)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw_guess    (sw_guess),
    .key_go_n    (key_go_n),
    .new_game    (new_game),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess_code  (guess_code),
    .bad_letter  (bad_letter),
    .dup_guess   (dup_guess),
    .guess_count (guess_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [5:0] code;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_bad = 0;
  int         n_dup = 0;
  int         m_count = 0;
  bit [63:0]  m_hist = '0;
  bit         prev_valid = 1'b0;
  bit         ended = 1'b0;
  logic [5:0] prev_code = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of a recognised press, from the letter rules and guess history.
  function automatic int kind_of(input logic [5:0] c);
    if (c < 6'h0A || c > 6'h23) return K_BAD;
    if (DUP_EN && m_hist[c]) return K_DUP;
    return K_ISSUE;
  endfunction

  task automatic monitor();
    int         front;
    logic [5:0] c;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("reset_valid", guess_valid, 0);
        chk("reset_code", guess_code, 0);
        chk("reset_bad", bad_letter, 0);
        chk("reset_dup", dup_guess, 0);
        chk("reset_count", guess_count, 0);
        exp_q.delete();
        m_count = 0;
        m_hist = '0;
        prev_valid = 1'b0;
        ended = 1'b0;
      end else begin
        front = (exp_q.size() > 0) ? exp_q[0].kind : -1;
        if (front == K_ISSUE) begin
          if (guess_valid) chk("valid_code", guess_code, exp_q[0].code);
        end else begin
          chk("valid_unexpected", guess_valid, 0);
        end
        if (ended) chk("valid_after_end", guess_valid, 0);
        if (prev_valid && !ended) chk("valid_held", guess_valid, 1);
        if (guess_valid && prev_valid) chk("code_stable", guess_code, prev_code);
        if (front == K_BAD && bad_letter) begin
          chk("bad_code", guess_code, exp_q[0].code);
          void'(exp_q.pop_front());
        end else begin
          chk("bad_unexpected", bad_letter, 0);
        end
        if (front == K_DUP && dup_guess) begin
          chk("dup_code", guess_code, exp_q[0].code);
          void'(exp_q.pop_front());
        end else begin
          chk("dup_unexpected", dup_guess, 0);
        end
        chk("guess_count", guess_count, m_count);
        if (guess_valid) n_valid++;
        if (bad_letter) n_bad++;
        if (dup_guess) n_dup++;
        ended = 1'b0;
        if (guess_valid && (guess_ready || new_game) && front == K_ISSUE) begin
          ended = 1'b1;
          c = exp_q[0].code;
          void'(exp_q.pop_front());
          if (!new_game) begin
            m_hist[c] = 1'b1;
            m_count = (m_count == 31) ? 31 : m_count + 1;
          end
        end
        if (new_game) begin
          m_count = 0;
          m_hist = '0;
        end
        prev_valid = guess_valid;
        prev_code = guess_code;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] code, input int low_cycles, input bit recognised);
    exp_t e;
    sw_guess = code;
    step(4);
    if (recognised) begin
      e.kind = kind_of(code);
      e.code = code;
      exp_q.push_back(e);
    end
    key_go_n = 1'b0;
    step(low_cycles);
    key_go_n = 1'b1;
  endtask

  task automatic settle();
    step(16);
    chk("outcome_seen", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!guess_valid && t < 30) begin
      step(1);
      t++;
    end
    chk("wait_valid", guess_valid, 1);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step(1);
    new_game = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_valid;
    int b_bad;
    int b_dup;
    fork
      monitor();
    join_none
    #2 resetn = 1'b1;
    step(3);
    resetn = 1'b0;
    step(2);
    chk("init_count", guess_count, 0);
    chk("init_valid", guess_valid, 0);

    // Accepted letter with ready already high.
    guess_ready = 1'b1;
    b_valid = n_valid;
    press(6'h1C, 6, 1'b1);
    settle();
    chk("s1_count", guess_count, 1);
    chk("s1_valid_cycles", n_valid - b_valid, 1);
    chk("s1_code", guess_code, 'h1C);

    // Short press is filtered out.
    b_valid = n_valid;
    press(6'h1C, 3, 1'b0);
    settle();
    chk("short_no_valid", n_valid - b_valid, 0);
    chk("short_count", guess_count, 1);

    // Illegal codes: dash, just past Z, just before A, all ones.
    b_valid = n_valid;
    b_bad = n_bad;
    press(6'h00, 6, 1'b1);
    settle();
    chk("dash_bad", n_bad - b_bad, 1);
    chk("dash_code", guess_code, 'h00);
    press(6'h24, 6, 1'b1);
    settle();
    chk("past_z_bad", n_bad - b_bad, 2);
    press(6'h09, 6, 1'b1);
    settle();
    press(6'h3F, 6, 1'b1);
    settle();
    chk("illegal_bad_total", n_bad - b_bad, 4);
    chk("illegal_no_valid", n_valid - b_valid, 0);
    chk("illegal_count", guess_count, 1);

    // Stalled handshake; switches move while the guess is pending.
    pulse_new_game();
    chk("ng_clear_count", guess_count, 0);
    guess_ready = 1'b0;
    press(6'h1C, 6, 1'b1);
    wait_valid();
    sw_guess = 6'h0A;
    step(10);
    chk("hold_valid", guess_valid, 1);
    chk("hold_code", guess_code, 'h1C);
    guess_ready = 1'b1;
    step(1);
    chk("xfer_valid_low", guess_valid, 0);
    chk("xfer_count", guess_count, 1);
    settle();

    // Same letter twice.
    pulse_new_game();
    press(6'h1D, 6, 1'b1);
    settle();
    chk("dup_first_count", guess_count, 1);
    b_dup = n_dup;
    press(6'h1D, 6, 1'b1);
    settle();
    chk("dup_second_count", guess_count, DUP_EN ? 1 : 2);
    chk("dup_pulses", n_dup - b_dup, DUP_EN ? 1 : 0);

    // new_game while a guess is pending.
    guess_ready = 1'b0;
    press(6'h1E, 6, 1'b1);
    wait_valid();
    pulse_new_game();
    chk("ng_issue_valid", guess_valid, 0);
    chk("ng_issue_count", guess_count, 0);
    settle();
    guess_ready = 1'b1;
    press(6'h1D, 6, 1'b1);
    settle();
    chk("ng_next_count", guess_count, 1);

    // Range boundaries A and Z are letters.
    press(6'h0A, 6, 1'b1);
    settle();
    press(6'h23, 6, 1'b1);
    settle();
    chk("bounds_count", guess_count, 3);

    // new_game on the same edge as a transfer.
    guess_ready = 1'b0;
    press(6'h14, 6, 1'b1);
    wait_valid();
    guess_ready = 1'b1;
    pulse_new_game();
    chk("coincide_valid", guess_valid, 0);
    chk("coincide_count", guess_count, 0);
    settle();
    press(6'h14, 6, 1'b1);
    settle();
    chk("coincide_next_count", guess_count, 1);

    // Reset in the middle of a handshake drops the guess.
    guess_ready = 1'b0;
    press(6'h15, 6, 1'b1);
    wait_valid();
    resetn = 1'b1;
    step(2);
    chk("rst_mid_valid", guess_valid, 0);
    chk("rst_mid_count", guess_count, 0);
    resetn = 1'b0;
    guess_ready = 1'b1;
    step(6);
    chk("rst_mid_no_xfer", guess_count, 0);
    chk("rst_mid_valid_after", guess_valid, 0);

`ifndef GUESS_DUP_FILTER_EN
    // Count saturates at 31.
    for (int i = 0; i < 32; i++) begin
      press(6'h0A, 6, 1'b1);
      settle();
    end
    chk("sat_count", guess_count, 31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
